// File: rtl/ahb_timer_pkg.sv
// Shared register map, CTRL field positions and channel register selector
// for the AHB timer array.
package ahb_timer_pkg;

  localparam logic [31:0] CTRL_OFF    = 32'h0000_0000;
  localparam logic [31:0] LOAD_OFF    = 32'h0000_0004;
  localparam logic [31:0] COUNT_OFF   = 32'h0000_0008;
  localparam logic [31:0] CMP_OFF     = 32'h0000_000C;
  localparam logic [31:0] STATUS_OFF  = 32'h0000_0100;
  localparam logic [31:0] IE_OFF      = 32'h0000_0104;
  localparam logic [31:0] CH_STRIDE   = 32'h0000_0010;

  localparam int EN_BIT      = 0;
  localparam int DIR_BIT     = 1;
  localparam int ONESHOT_BIT = 2;
  localparam int PWM_EN_BIT  = 3;
  localparam int PRESC_LSB   = 8;

  localparam logic [31:0] UNMAPPED_RD = 32'hDEAD_BEEF;

  // Word select inside one channel's 16-byte window (address bits [3:2]).
  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_LOAD  = 2'd1,
    REG_COUNT = 2'd2,
    REG_CMP   = 2'd3
  } chan_reg_e;

endpackage

// File: rtl/ahb_timer_array_if.sv
// AHB-Lite slave-side signal bundle for the timer array.
interface ahb_timer_array_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADYOUT;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS,
    input  HREADYOUT, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HWRITE, HADDR, HWDATA, HSIZE, HTRANS,
    output HREADYOUT, HRDATA
  );
endinterface

// File: rtl/ahb_timer_chan.sv
// One timer channel: CTRL/LOAD/COUNT/CMP registers, prescaler, terminal-count
// pulse (combinational, consumed by the STATUS register) and registered PWM.
module ahb_timer_chan
  import ahb_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PSW   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_ctrl_i,
  input  logic             wr_load_i,
  input  logic             wr_count_i,
  input  logic             wr_cmp_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      ctrl_rd_o,
  output logic [WIDTH-1:0] load_o,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] cmp_o,
  output logic             tc_o,
  output logic             pwm_o
);

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(1'b0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

  logic             en_q, en_d, dir_q, dir_d, os_q, os_d, pwm_en_q, pwm_en_d;
  logic [PSW-1:0]   presc_q, presc_d, pcnt_q, pcnt_d;
  logic [WIDTH-1:0] load_q, load_d, cmp_q, cmp_d, count_q, count_d;
  logic             pwm_q, pwm_d;
  logic             tick_s, wrap_s, tc_s;

  // Next-state: prescaler, counter with wrap, one-shot stop, bus writes, PWM.
  always_comb begin
    tick_s = en_q & (pcnt_q == presc_q);
    wrap_s = dir_q ? (count_q == ZERO) : (count_q == load_q);
    // A COUNT write overrides the tick, so no terminal count that cycle.
    tc_s   = tick_s & wrap_s & ~wr_count_i;

    if (wr_count_i) begin
      count_d = wdata_i[WIDTH-1:0];
    end else if (tick_s) begin
      if (wrap_s) count_d = dir_q ? load_q : ZERO;
      else        count_d = dir_q ? (count_q - ONE) : (count_q + ONE);
    end else begin
      count_d = count_q;
    end

    if (wr_ctrl_i || !en_q || tick_s) pcnt_d = PSW'(1'b0);
    else                              pcnt_d = pcnt_q + PSW'(1'b1);

    // CTRL write wins over the one-shot EN clear.
    if (wr_ctrl_i) begin
      en_d     = wdata_i[EN_BIT];
      dir_d    = wdata_i[DIR_BIT];
      os_d     = wdata_i[ONESHOT_BIT];
      pwm_en_d = wdata_i[PWM_EN_BIT];
      presc_d  = wdata_i[PRESC_LSB +: PSW];
    end else begin
      en_d     = (tc_s & os_q) ? 1'b0 : en_q;
      dir_d    = dir_q;
      os_d     = os_q;
      pwm_en_d = pwm_en_q;
      presc_d  = presc_q;
    end

    if (wr_load_i) load_d = wdata_i[WIDTH-1:0];
    else           load_d = load_q;

    if (wr_cmp_i) cmp_d = wdata_i[WIDTH-1:0];
    else          cmp_d = cmp_q;

    pwm_d = pwm_en_q & en_q & (count_q < cmp_q);
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      dir_q    <= 1'b0;
      os_q     <= 1'b0;
      pwm_en_q <= 1'b0;
      presc_q  <= PSW'(1'b0);
      pcnt_q   <= PSW'(1'b0);
      load_q   <= ZERO;
      cmp_q    <= ZERO;
      count_q  <= ZERO;
      pwm_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      dir_q    <= dir_d;
      os_q     <= os_d;
      pwm_en_q <= pwm_en_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      load_q   <= load_d;
      cmp_q    <= cmp_d;
      count_q  <= count_d;
      pwm_q    <= pwm_d;
    end
  end

  // CTRL read-back word assembled from the individual fields.
  always_comb begin
    ctrl_rd_o                      = 32'h0000_0000;
    ctrl_rd_o[EN_BIT]              = en_q;
    ctrl_rd_o[DIR_BIT]             = dir_q;
    ctrl_rd_o[ONESHOT_BIT]         = os_q;
    ctrl_rd_o[PWM_EN_BIT]          = pwm_en_q;
    ctrl_rd_o[PRESC_LSB +: PSW]    = presc_q;
  end

  assign load_o  = load_q;
  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign tc_o    = tc_s;
  assign pwm_o   = pwm_q;

endmodule

// File: rtl/ahb_timer_array.sv
// AHB-Lite timer array: address-phase capture, write decode, read mux,
// W1C STATUS / IE registers and the registered interrupt.
module ahb_timer_array
  import ahb_timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int PSW   = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_timer_array_if.slave    bus,
  output logic [NCH-1:0]      pwm_out,
  output logic                irq,
  output logic [NCH-1:0]      gpio_oeb
);

  logic             sel_q, write_q;
  logic [31:0]      addr_q;
  logic [NCH-1:0]   status_q, status_d, ie_q, ie_d;
  logic             irq_q, irq_d;
  logic             wr_s, ch_hit_s, st_hit_s, ie_hit_s;
  logic [2:0]       ch_idx_s;
  chan_reg_e        reg_sel_s;
  logic [NCH-1:0]   wr_ch_s, tc_s, pwm_s;
  logic [31:0]      ctrl_rd_s [NCH];
  logic [WIDTH-1:0] load_rd_s [NCH];
  logic [WIDTH-1:0] count_rd_s [NCH];
  logic [WIDTH-1:0] cmp_rd_s [NCH];
  logic [31:0]      ch_word_s, rdata_s;

  // Address-phase capture; held while a data phase is stalled.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'h0000_0000;
    end else if (bus.HREADY) begin
      sel_q   <= bus.HSEL & bus.HTRANS[1];
      write_q <= bus.HWRITE;
      addr_q  <= bus.HADDR;
    end
  end

  assign wr_s      = sel_q & write_q & bus.HREADY;
  assign ch_hit_s  = (addr_q < (32'(NCH) * CH_STRIDE));
  assign st_hit_s  = (addr_q[31:2] == STATUS_OFF[31:2]);
  assign ie_hit_s  = (addr_q[31:2] == IE_OFF[31:2]);
  assign ch_idx_s  = addr_q[6:4];
  assign reg_sel_s = chan_reg_e'(addr_q[3:2]);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign wr_ch_s[g] = wr_s & ch_hit_s & (ch_idx_s == 3'(g));

    ahb_timer_chan #(.WIDTH(WIDTH), .PSW(PSW)) u_chan (
      .clk_i      (HCLK),
      .rst_ni     (HRESETn),
      .wr_ctrl_i  (wr_ch_s[g] & (reg_sel_s == REG_CTRL)),
      .wr_load_i  (wr_ch_s[g] & (reg_sel_s == REG_LOAD)),
      .wr_count_i (wr_ch_s[g] & (reg_sel_s == REG_COUNT)),
      .wr_cmp_i   (wr_ch_s[g] & (reg_sel_s == REG_CMP)),
      .wdata_i    (bus.HWDATA),
      .ctrl_rd_o  (ctrl_rd_s[g]),
      .load_o     (load_rd_s[g]),
      .count_o    (count_rd_s[g]),
      .cmp_o      (cmp_rd_s[g]),
      .tc_o       (tc_s[g]),
      .pwm_o      (pwm_s[g])
    );
  end

  // Read mux, combinational from the registered address.
  always_comb begin
    ch_word_s = UNMAPPED_RD;
    for (int i = 0; i < NCH; i++) begin
      if (ch_idx_s == 3'(i)) begin
        case (reg_sel_s)
          REG_CTRL:  ch_word_s = ctrl_rd_s[i];
          REG_LOAD:  ch_word_s = 32'(load_rd_s[i]);
          REG_COUNT: ch_word_s = 32'(count_rd_s[i]);
          REG_CMP:   ch_word_s = 32'(cmp_rd_s[i]);
          default:   ch_word_s = UNMAPPED_RD;
        endcase
      end else begin
        ch_word_s = ch_word_s;
      end
    end

    if (ch_hit_s)      rdata_s = ch_word_s;
    else if (st_hit_s) rdata_s = 32'(status_q);
    else if (ie_hit_s) rdata_s = 32'(ie_q);
    else               rdata_s = UNMAPPED_RD;
  end

  // STATUS W1C with hardware set winning, IE write, interrupt level.
  always_comb begin
    if (wr_s && st_hit_s) status_d = status_q & ~bus.HWDATA[NCH-1:0];
    else                  status_d = status_q;
    status_d = status_d | tc_s;

    if (wr_s && ie_hit_s) ie_d = bus.HWDATA[NCH-1:0];
    else                  ie_d = ie_q;

    irq_d = |(status_q & ie_q);
  end

  // STATUS, IE and interrupt registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      status_q <= {NCH{1'b0}};
      ie_q     <= {NCH{1'b0}};
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.HRDATA    = rdata_s;
  assign bus.HREADYOUT = 1'b1;
  assign pwm_out       = pwm_s;
  assign irq           = irq_q;
  assign gpio_oeb      = {NCH{~HRESETn}};

endmodule

// File: tb/tb_ahb_timer_array.sv
// Bench for ahb_timer_array: register table, directed timing sequences and a
// randomized phase checked against a cycle-level behavioural model.
module tb_ahb_timer_array;
  localparam int NCH = 4;
  localparam int WIDTH = 16;
  localparam int PSW = 8;
  localparam longint MASK = (64'd1 << WIDTH) - 64'd1;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [NCH-1:0] pwm_out, gpio_oeb;
  logic irq;

  ahb_timer_array_if bus();

  ahb_timer_array #(.NCH(NCH), .WIDTH(WIDTH), .PSW(PSW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus.slave),
    .pwm_out(pwm_out), .irq(irq), .gpio_oeb(gpio_oeb)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_en[NCH], m_dir[NCH], m_os[NCH], m_pe[NCH], m_presc[NCH], m_pc[NCH], m_pwm[NCH];
  longint m_load[NCH], m_count[NCH], m_cmp[NCH];
  int m_status, m_ie, m_irq, m_valid, m_write;
  longint m_addr;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_en[c] = 0; m_dir[c] = 0; m_os[c] = 0; m_pe[c] = 0; m_presc[c] = 0;
      m_pc[c] = 0; m_pwm[c] = 0; m_load[c] = 0; m_count[c] = 0; m_cmp[c] = 0;
    end
    m_status = 0; m_ie = 0; m_irq = 0; m_valid = 0; m_write = 0; m_addr = 0;
  endtask

  task automatic model_step();
    bit wr, tick, term, cw;
    longint wd, nxt;
    int tc_vec, irq_next;
    wr = (m_valid != 0) && (m_write != 0);
    wd = longint'(bus.HWDATA);
    irq_next = ((m_status & m_ie) != 0) ? 1 : 0;
    tc_vec = 0;
    for (int c = 0; c < NCH; c++) begin
      tick = (m_en[c] != 0) && (m_pc[c] == m_presc[c]);
      cw = wr && (m_addr == longint'(c * 16 + 8));
      m_pwm[c] = (m_pe[c] != 0 && m_en[c] != 0 && m_count[c] < m_cmp[c]) ? 1 : 0;
      term = tick && (m_dir[c] != 0 ? m_count[c] == 0 : m_count[c] == m_load[c]);
      nxt = m_count[c];
      if (tick) begin
        if (term) nxt = (m_dir[c] != 0) ? m_load[c] : 0;
        else if (m_dir[c] != 0) nxt = (m_count[c] - 1) & MASK;
        else nxt = (m_count[c] + 1) & MASK;
      end
      m_pc[c] = (m_en[c] == 0 || tick) ? 0 : m_pc[c] + 1;
      if (term && !cw) begin
        tc_vec |= (1 << c);
        if (m_os[c] != 0) m_en[c] = 0;
      end
      m_count[c] = cw ? (wd & MASK) : nxt;
      if (wr && m_addr == longint'(c * 16)) begin
        m_en[c] = int'(wd & 1); m_dir[c] = int'((wd >> 1) & 1);
        m_os[c] = int'((wd >> 2) & 1); m_pe[c] = int'((wd >> 3) & 1);
        m_presc[c] = int'((wd >> 8) & 255); m_pc[c] = 0;
      end
      if (wr && m_addr == longint'(c * 16 + 4)) m_load[c] = wd & MASK;
      if (wr && m_addr == longint'(c * 16 + 12)) m_cmp[c] = wd & MASK;
    end
    if (wr && m_addr == 64'h100) m_status &= ~int'(wd);
    m_status = (m_status | tc_vec) & ((1 << NCH) - 1);
    if (wr && m_addr == 64'h104) m_ie = int'(wd) & ((1 << NCH) - 1);
    m_irq = irq_next;
    if (bus.HREADY) begin
      m_valid = (bus.HSEL && bus.HTRANS[1]) ? 1 : 0;
      m_write = bus.HWRITE ? 1 : 0;
      m_addr = longint'(bus.HADDR) & ~64'd3;
    end
  endtask

  function automatic longint mread(input longint a);
    int c;
    if (a < NCH * 16) begin
      c = int'(a >> 4);
      case ((a >> 2) & 3)
        0: return longint'((m_presc[c] << 8) | (m_pe[c] << 3) | (m_os[c] << 2) | (m_dir[c] << 1) | m_en[c]);
        1: return m_load[c];
        2: return m_count[c];
        default: return m_cmp[c];
      endcase
    end
    if (a == 64'h100) return longint'(m_status);
    if (a == 64'h104) return longint'(m_ie);
    return 64'hDEAD_BEEF;
  endfunction

  function automatic logic [NCH-1:0] mpwm();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (m_pwm[c] != 0);
    return r;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge HCLK or negedge HRESETn);
      if (!HRESETn) model_reset();
      else model_step();
    end
  end

  // Continuous output comparison during the randomized phase.
  always @(negedge HCLK) begin
    if (mon_en && HRESETn) begin
      check("pwm_out", longint'(pwm_out), longint'(mpwm()));
      check("irq", longint'(irq), longint'(m_irq));
      check("hreadyout", longint'(bus.HREADYOUT), 64'd1);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic drive_addr(input logic [31:0] a, input logic w);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a; bus.HWRITE = w;
  endtask

  task automatic drive_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK); drive_addr(a, 1'b1);
    @(negedge HCLK); bus.HWDATA = d; drive_idle();
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK); drive_addr(a, 1'b0);
    @(negedge HCLK); drive_idle(); d = bus.HRDATA;
  endtask

  task automatic do_reset();
    @(negedge HCLK); drive_idle(); HRESETn = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    int hi, sel, ch;
    logic [31:0] a, d;

    vecs[0]  = '{1'b1, 32'h000, 32'hFFFF_FFFE, 32'h0000_FF0E};
    vecs[1]  = '{1'b1, 32'h014, 32'hABCD_1234, 32'h0000_1234};
    vecs[2]  = '{1'b1, 32'h02C, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vecs[3]  = '{1'b1, 32'h038, 32'h0001_0005, 32'h0000_0005};
    vecs[4]  = '{1'b1, 32'h104, 32'hFFFF_FFFF, 32'h0000_000F};
    vecs[5]  = '{1'b0, 32'h100, 32'h0000_0000, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h200, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h200, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 32'h0F0, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b0, 32'h108, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 32'h000, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h03C, 32'h0000_0000, 32'h0000_0000};

    bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = 32'h0;
    bus.HWDATA = 32'h0; bus.HSIZE = 3'b010; bus.HTRANS = 2'b00;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    check("rst_pwm", longint'(pwm_out), 64'd0);
    check("rst_irq", longint'(irq), 64'd0);
    check("rst_oeb", longint'(gpio_oeb), 64'hF);
    check("rst_hrdata", longint'(bus.HRDATA), 64'd0);
    check("rst_hreadyout", longint'(bus.HREADYOUT), 64'd1);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("run_oeb", longint'(gpio_oeb), 64'd0);

    // Register table.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) ahb_write(vecs[i].addr, vecs[i].wdata);
      ahb_read(vecs[i].addr, rd);
      check($sformatf("table[%0d]", i), longint'(rd), longint'(vecs[i].exp));
    end
    do_reset();

    // Ch0 up, LOAD=3, PRESC=0: 0,1,2,3,0,1 per cycle.
    ahb_write(32'h004, 32'd3);
    @(negedge HCLK); drive_addr(32'h000, 1'b1);
    @(negedge HCLK); bus.HWDATA = 32'h1; drive_addr(32'h008, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      check($sformatf("ch0_count[%0d]", k), longint'(bus.HRDATA), longint'(k % 4));
    end
    drive_idle();
    ahb_read(32'h100, rd);
    check("ch0_status", longint'(rd[0]), 64'd1);
    ahb_write(32'h000, 32'h0);
    ahb_write(32'h100, 32'hF);

    // Ch1 down, PRESC=2, LOAD=COUNT=5.
    ahb_write(32'h014, 32'd5);
    ahb_write(32'h018, 32'd5);
    @(negedge HCLK); drive_addr(32'h010, 1'b1);
    @(negedge HCLK); bus.HWDATA = 32'h0000_0203; drive_addr(32'h018, 1'b0);
    for (int k = 0; k < 19; k++) begin
      @(negedge HCLK);
      check($sformatf("ch1_count[%0d]", k), longint'(bus.HRDATA),
            (k < 15) ? longint'(5 - k / 3) : ((k < 18) ? 64'd0 : 64'd5));
    end
    drive_idle();
    ahb_read(32'h100, rd);
    check("ch1_status", longint'(rd[1]), 64'd1);
    ahb_write(32'h010, 32'h0);
    ahb_write(32'h100, 32'hF);

    // Ch2 one-shot with interrupt.
    ahb_write(32'h104, 32'h4);
    ahb_write(32'h024, 32'd2);
    @(negedge HCLK); drive_addr(32'h020, 1'b1);
    @(negedge HCLK); bus.HWDATA = 32'h5; drive_addr(32'h100, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      check($sformatf("ch2_status[%0d]", k), longint'(bus.HRDATA[2]), (k >= 3) ? 64'd1 : 64'd0);
      check($sformatf("ch2_irq[%0d]", k), longint'(irq), (k >= 4) ? 64'd1 : 64'd0);
    end
    drive_idle();
    ahb_read(32'h020, rd);
    check("ch2_ctrl", longint'(rd), 64'h4);
    ahb_read(32'h028, rd);
    check("ch2_count", longint'(rd), 64'd0);
    ahb_write(32'h100, 32'h4);
    @(negedge HCLK);
    check("ch2_irq_lag", longint'(irq), 64'd1);
    @(negedge HCLK);
    check("ch2_irq_clr", longint'(irq), 64'd0);
    ahb_read(32'h100, rd);
    check("ch2_status_clr", longint'(rd), 64'd0);

    // Ch3 PWM: LOAD=9, CMP=3 -> 6 high in 20 cycles; CMP=0 -> none.
    ahb_write(32'h034, 32'd9);
    ahb_write(32'h03C, 32'd3);
    ahb_write(32'h030, 32'h9);
    @(negedge HCLK);
    hi = 0;
    repeat (20) begin @(negedge HCLK); hi += int'(pwm_out[3]); end
    check("ch3_pwm_duty", longint'(hi), 64'd6);
    ahb_write(32'h03C, 32'd0);
    @(negedge HCLK);
    hi = 0;
    repeat (20) begin @(negedge HCLK); hi += int'(pwm_out[3]); end
    check("ch3_pwm_cmp0", longint'(hi), 64'd0);
    ahb_write(32'h030, 32'h0);

    // Terminal count coinciding with a W1C of the same STATUS bit.
    ahb_write(32'h008, 32'd0);
    ahb_write(32'h100, 32'hF);
    ahb_write(32'h000, 32'h1);
    repeat (2) @(negedge HCLK);
    ahb_write(32'h100, 32'h1);
    ahb_read(32'h100, rd);
    check("w1c_vs_set", longint'(rd[0]), 64'd1);

    // COUNT write coinciding with a terminal tick.
    ahb_write(32'h000, 32'h0);
    ahb_write(32'h008, 32'd0);
    ahb_write(32'h100, 32'hF);
    ahb_write(32'h000, 32'h1);
    repeat (2) @(negedge HCLK);
    @(negedge HCLK); drive_addr(32'h008, 1'b1);
    @(negedge HCLK); bus.HWDATA = 32'd7; drive_addr(32'h008, 1'b0);
    @(negedge HCLK); drive_idle();
    check("count_wr_wins", longint'(bus.HRDATA), 64'd7);
    ahb_read(32'h100, rd);
    check("count_wr_no_tc", longint'(rd), 64'd0);
    ahb_write(32'h000, 32'h0);

    // Randomized phase against the model.
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          sel = int'($urandom_range(0, 5));
          ch = int'($urandom_range(0, NCH - 1));
          case (sel)
            0: begin a = 32'(ch * 16);      d = ($urandom_range(0, 3) << 8) | $urandom_range(0, 15); end
            1: begin a = 32'(ch * 16 + 4);  d = $urandom_range(0, 11); end
            2: begin a = 32'(ch * 16 + 8);  d = $urandom_range(0, 11); end
            3: begin a = 32'(ch * 16 + 12); d = $urandom_range(0, 13); end
            4: begin a = 32'h100;           d = $urandom_range(0, 15); end
            default: begin a = 32'h104;     d = $urandom_range(0, 15); end
          endcase
          ahb_write(a, d);
        end
        6, 7, 8: begin
          sel = int'($urandom_range(0, 18));
          if (sel < 16) a = 32'(sel * 4);
          else if (sel == 16) a = 32'h100;
          else if (sel == 17) a = 32'h104;
          else a = 32'h200;
          ahb_read(a, rd);
          check($sformatf("rand_rd[%0h]", a), longint'(rd), mread(longint'(a)));
        end
        default: repeat ($urandom_range(1, 8)) @(negedge HCLK);
      endcase
    end
    mon_en = 1'b0;

    // Reset mid-count with irq and PWM active.
    ahb_write(32'h004, 32'd1);
    ahb_write(32'h00C, 32'd1);
    ahb_write(32'h104, 32'h1);
    ahb_write(32'h000, 32'h9);
    repeat (4) @(negedge HCLK);
    check("pre_rst_irq", longint'(irq), 64'd1);
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_pwm", longint'(pwm_out), 64'd0);
    check("mid_rst_irq", longint'(irq), 64'd0);
    check("mid_rst_hrdata", longint'(bus.HRDATA), 64'd0);
    check("mid_rst_oeb", longint'(gpio_oeb), 64'hF);
    check("mid_rst_hreadyout", longint'(bus.HREADYOUT), 64'd1);
    @(negedge HCLK); HRESETn = 1'b1;
    for (int r = 0; r < 18; r++) begin
      a = (r < 16) ? 32'(r * 4) : ((r == 16) ? 32'h100 : 32'h104);
      ahb_read(a, rd);
      check($sformatf("post_rst[%0h]", a), longint'(rd), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
